// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Round-robin arbiter that shares one single-write/single-read register file
//   between two requesters (A and B). Each granted transaction reads or writes
//   one register and takes exactly three cycles: IDLE (grant), ACCESS (regfile
//   cycle), RESP (done pulse). Writes return the register's pre-write value.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_x/we_x/addr_x/wdata_x   requester x transaction (x = a, b), held until done
//   done_x                one-cycle completion pulse for requester x
//   rdata_x               read data for requester x, held until its next done
//   rf_writenum/rf_write/rf_data_in/rf_readnum   drive the regfile
//   rf_data_out           combinational regfile read data
//   busy                  high whenever a transaction is in flight
module regfile_arbiter #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          done_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          done_b,
  output logic [DW-1:0] rdata_b,
  output logic [AW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_data_in,
  output logic [AW-1:0] rf_readnum,
  input  logic [DW-1:0] rf_data_out,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // op_id / last_id: 0 = requester A, 1 = requester B
  logic          op_id;
  logic          op_we;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;
  logic          last_id;

  logic          grant;
  logic          grant_id;

  // Tie goes to whoever was not served last; last_id resets to B so A wins
  // the first tie after reset.
  always_comb begin
    grant    = req_a | req_b;
    grant_id = (req_a & req_b) ? ~last_id : ~req_a;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_id  <= 1'b1;
      op_id    <= 1'b0;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      state <= state_nxt;
      // ---- grant edge: sample the winning requester ----
      if (state == IDLE && grant) begin
        op_id    <= grant_id;
        last_id  <= grant_id;
        op_we    <= grant_id ? we_b    : we_a;
        op_addr  <= grant_id ? addr_b  : addr_a;
        op_wdata <= grant_id ? wdata_b : wdata_a;
      end
      // ---- access edge: capture pre-write register contents ----
      if (state == ACCESS) begin
        if (op_id) rdata_b <= rf_data_out;
        else       rdata_a <= rf_data_out;
      end
    end
  end

  // Address/data come straight from the latched operation registers, so they
  // are glitch-free and simply hold their last value while idle.
  assign rf_writenum = op_addr;
  assign rf_readnum  = op_addr;
  assign rf_data_in  = op_wdata;
  // Reset in the access cycle must block the write at the closing edge.
  assign rf_write    = (state == ACCESS) & op_we & ~reset;

  assign done_a = (state == RESP) & ~op_id;
  assign done_b = (state == RESP) &  op_id;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter
//   Drives two requesters against regfile_arbiter connected to a behavioural
//   8x16 register file. Requester tasks push expected transactions into
//   per-requester queues; a monitor pops on every done pulse and compares the
//   returned data against a reference register array updated in service order,
//   and checks the round-robin tie rule, done exclusivity and spacing.
module tb_regfile_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          done_a, done_b, rf_write, busy;
  logic [DW-1:0] rdata_a, rdata_b, rf_data_in, rf_data_out;
  logic [AW-1:0] rf_writenum, rf_readnum;

  regfile_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .done_a(done_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .done_b(done_b), .rdata_b(rdata_b),
    .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in),
    .rf_readnum(rf_readnum), .rf_data_out(rf_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural register file: synchronous write, combinational read.
  logic [DW-1:0] rf_mem [8];
  initial for (int i = 0; i < 8; i++) rf_mem[i] = '0;
  always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
  assign rf_data_out = rf_mem[rf_readnum];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } txn_t;

  txn_t          qa[$];
  txn_t          qb[$];
  logic [DW-1:0] ref_mem [8];
  int            checks = 0;
  int            passes = 0;
  int            cyc = 0;
  int            log_id[$];
  int            log_cyc[$];

  initial for (int i = 0; i < 8; i++) ref_mem[i] = '0;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic          last_srv;
    logic [1:0]    h1, h2;
    logic [DW-1:0] held_a, held_b, exp_d;
    int            last_done;
    txn_t          t;
    last_srv = 1'b1; h1 = '0; h2 = '0; held_a = '0; held_b = '0; last_done = -1;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_srv = 1'b1; h1 = '0; h2 = '0; held_a = '0; held_b = '0; last_done = -1;
      end else begin
        if (done_a | done_b) begin
          chk("done_exclusive", {31'd0, done_a & done_b}, 32'd0);
          if (last_done >= 0) chk("done_spacing_ge3", {31'd0, (cyc - last_done) >= 3}, 32'd1);
          last_done = cyc;
        end
        if (done_a) begin
          // h2 holds the requests seen at the grant edge of this transaction
          if (h2 == 2'b11) chk("tie_winner_a", {31'd0, 1'b0}, {31'd0, ~last_srv});
          last_srv = 1'b0;
          log_id.push_back(0); log_cyc.push_back(cyc);
          chk("a_expected_pending", {31'd0, qa.size() != 0}, 32'd1);
          if (qa.size() != 0) begin
            t = qa.pop_front();
            exp_d = ref_mem[t.addr];
            if (t.we) ref_mem[t.addr] = t.wd;
            chk("rdata_a", {16'd0, rdata_a}, {16'd0, exp_d});
            held_a = exp_d;
          end
          chk("rdata_b_held", {16'd0, rdata_b}, {16'd0, held_b});
        end
        if (done_b) begin
          if (h2 == 2'b11) chk("tie_winner_b", {31'd0, 1'b1}, {31'd0, ~last_srv});
          last_srv = 1'b1;
          log_id.push_back(1); log_cyc.push_back(cyc);
          chk("b_expected_pending", {31'd0, qb.size() != 0}, 32'd1);
          if (qb.size() != 0) begin
            t = qb.pop_front();
            exp_d = ref_mem[t.addr];
            if (t.we) ref_mem[t.addr] = t.wd;
            chk("rdata_b", {16'd0, rdata_b}, {16'd0, exp_d});
            held_b = exp_d;
          end
          chk("rdata_a_held", {16'd0, rdata_a}, {16'd0, held_a});
        end
        h2 = h1;
        h1 = {req_a, req_b};
      end
    end
  end

  // ---------------- requester tasks (called at posedge + #1) ----------------
  task automatic set_req(input bit id, input logic we, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd);
    txn_t t;
    t.we = we; t.addr = ad; t.wd = wd;
    if (id) begin req_b = 1'b1; we_b = we; addr_b = ad; wdata_b = wd; qb.push_back(t); end
    else    begin req_a = 1'b1; we_a = we; addr_a = ad; wdata_a = wd; qa.push_back(t); end
  endtask

  task automatic idle(input bit id, input int n);
    if (id) req_b = 1'b0; else req_a = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves req high on return so a following call chains back-to-back.
  task automatic txn(input bit id, input logic we, input logic [AW-1:0] ad,
                     input logic [DW-1:0] wd);
    int k;
    logic d;
    set_req(id, we, ad, wd);
    k = 0;
    do begin
      @(negedge clk);
      d = id ? done_b : done_a;
      k++;
    end while (!d && k < 40);
    if (!d) chk(id ? "timeout_b" : "timeout_a", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic rand_driver(input bit id, input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(id, gap);
      txn(id, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
    end
    idle(id, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    #1;
    // 1: reset state
    do_reset(2);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_a", {31'd0, done_a}, 32'd0);
    chk("rst_done_b", {31'd0, done_b}, 32'd0);
    chk("rst_rdata_a", {16'd0, rdata_a}, 32'd0);
    chk("rst_rdata_b", {16'd0, rdata_b}, 32'd0);
    chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
    chk("rst_rf_writenum", {29'd0, rf_writenum}, 32'd0);
    chk("rst_rf_readnum", {29'd0, rf_readnum}, 32'd0);
    chk("rst_rf_data_in", {16'd0, rf_data_in}, 32'd0);
    @(posedge clk); #1;

    // 2: A writes R3 = 00FF with cycle-accurate timing, then reads it back
    set_req(1'b0, 1'b1, 3'd3, 16'h00FF);
    @(negedge clk);
    chk("t2_idle_rf_write", {31'd0, rf_write}, 32'd0);
    chk("t2_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t2_access_rf_write", {31'd0, rf_write}, 32'd1);
    chk("t2_access_writenum", {29'd0, rf_writenum}, 32'd3);
    chk("t2_access_data_in", {16'd0, rf_data_in}, 32'h00FF);
    chk("t2_access_done", {31'd0, done_a}, 32'd0);
    @(negedge clk);
    chk("t2_resp_done_a", {31'd0, done_a}, 32'd1);
    chk("t2_resp_rf_write", {31'd0, rf_write}, 32'd0);
    @(posedge clk); #1;
    idle(1'b0, 1);
    txn(1'b0, 1'b0, 3'd3, 16'h0000);
    chk("t2_read_r3", {16'd0, rdata_a}, 32'h00FF);
    idle(1'b0, 1);

    // 3: simultaneous requests after reset, A wins first
    do_reset(2);
    base = log_id.size();
    fork
      begin txn(1'b0, 1'b1, 3'd1, 16'h1111); idle(1'b0, 1); end
      begin txn(1'b1, 1'b0, 3'd1, 16'h0000); idle(1'b1, 1); end
    join
    chk("t3_count", log_id.size() - base, 32'd2);
    if (log_id.size() - base == 2) begin
      chk("t3_first_a", log_id[base], 32'd0);
      chk("t3_second_b", log_id[base+1], 32'd1);
    end
    chk("t3_rdata_b", {16'd0, rdata_b}, 32'h1111);

    // 4: both hold requests for four transactions -> A,B,A,B three cycles apart
    base = log_id.size();
    fork
      begin txn(1'b0, 1'b1, 3'd2, 16'hA001); txn(1'b0, 1'b0, 3'd4, 16'h0); idle(1'b0, 1); end
      begin txn(1'b1, 1'b1, 3'd4, 16'hB002); txn(1'b1, 1'b0, 3'd2, 16'h0); idle(1'b1, 1); end
    join
    chk("t4_count", log_id.size() - base, 32'd4);
    if (log_id.size() - base == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t4_order", log_id[base+i], (i % 2 == 0) ? 32'd0 : 32'd1);
        if (i > 0) chk("t4_spacing", log_cyc[base+i] - log_cyc[base+i-1], 32'd3);
      end
    end

    // 5: B overwrites R7 and gets the old value, then reads the new one
    txn(1'b0, 1'b1, 3'd7, 16'h0001); idle(1'b0, 1);
    txn(1'b1, 1'b1, 3'd7, 16'hBEEF);
    chk("t5_old_r7", {16'd0, rdata_b}, 32'h0001);
    idle(1'b1, 1);
    txn(1'b1, 1'b0, 3'd7, 16'h0000);
    chk("t5_new_r7", {16'd0, rdata_b}, 32'hBEEF);
    idle(1'b1, 1);

    // 6: reset during the access cycle of a write suppresses it
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd5; wdata_a = 16'hDEAD;
    @(posedge clk); #1;
    chk("t6_in_access", {31'd0, busy}, 32'd1);
    reset = 1'b1; req_a = 1'b0;
    #1 chk("t6_rf_write_blocked", {31'd0, rf_write}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_done", {31'd0, done_a | done_b}, 32'd0);
    end
    chk("t6_r5_unwritten", {16'd0, rf_mem[5]}, 32'd0);
    chk("t6_rdata_a_reset", {16'd0, rdata_a}, 32'd0);
    @(posedge clk); #1;
    txn(1'b0, 1'b0, 3'd5, 16'h0000);
    chk("t6_read_r5", {16'd0, rdata_a}, 32'd0);
    idle(1'b0, 1);

    // random concurrent traffic
    fork
      rand_driver(1'b0, 60);
      rand_driver(1'b1, 60);
    join
    repeat (5) @(posedge clk);
    #1;
    chk("drain_qa", qa.size(), 32'd0);
    chk("drain_qb", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

endmodule
